// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states,
// opcodes, ALU op / ALU control codes and datapath mux selects.
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format straight from the opcode; unknown opcodes fall back to I.
    function automatic logic [1:0] imm_src_for(input logic [6:0] opc);
        logic [1:0] imm;
        imm = IMM_I;
        case (opc)
            OP_SW:   imm = IMM_S;
            OP_BEQ:  imm = IMM_B;
            OP_JAL:  imm = IMM_J;
            default: imm = IMM_I;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps the FSM's ALU op plus funct fields onto the ALU
// operation code.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic       funct7,
    input  logic       opcode5,
    input  logic [2:0] funct3,
    output logic [2:0] alu_control
);

    // Forced add/sub for address and branch math, funct-driven otherwise.
    // Only register-register 000 can be a subtract; addi never is.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    3'b000:  alu_control = ({opcode5, funct7} == 2'b11) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  FETCH    | read instr at PC, PC+4 -> PC when memory is ready
//  DECODE   | read regs, branch target -> ALUOut, dispatch on opcode
//  MEMADR   | rs1 + imm -> ALUOut (load/store address)
//  MEMREAD  | read data memory at ALUOut, wait for ready
//  MEMWB    | loaded data -> rd
//  MEMWRITE | write data memory at ALUOut, strobe held until ready
//  EXECUTER | rs1 op rs2
//  EXECUTEI | rs1 op imm
//  ALUWB    | ALUOut -> rd
//  BEQ      | rs1 - rs2, take branch target when zero
//  JAL      | OldPC + 4 -> ALUOut, jump target -> PC
module multicycle_controller
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             adr_src,
    output logic             mem_write,
    output logic             ir_write,
    output logic [1:0]       result_src,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       imm_src,
    output logic             reg_write,
    output logic [2:0]       alu_control,
    output logic             illegal_instr,
    output logic [CNT_W-1:0] instr_retired
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       branch;
    logic       pc_update;
    logic       ir_write_int;
    logic       mem_write_int;
    logic       reg_write_int;
    logic       illegal_int;
    logic       retire;

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_next    = S_FETCH;
        adr_src       = 1'b0;
        ir_write_int  = 1'b0;
        mem_write_int = 1'b0;
        reg_write_int = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        illegal_int   = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_REGB;
        alu_op        = ALUOP_ADD;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b    = SRCB_FOUR;
                result_src   = RES_ALURESULT;
                ir_write_int = mem_ready;
                pc_update    = mem_ready;
                state_next   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ITYPE:     state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        state_next  = S_FETCH;
                        illegal_int = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                state_next = mem_ready ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src    = RES_DATA;
                reg_write_int = 1'b1;
                retire        = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src       = 1'b1;
                mem_write_int = 1'b1;
                retire        = mem_ready;
                state_next    = mem_ready ? S_FETCH : S_MEMWRITE;
            end
            S_EXECUTER: begin
                alu_src_a  = SRCA_REGA;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_int = 1'b1;
                retire        = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_REGA;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
                retire    = 1'b1;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_update  = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_retired <= '0;
        end else if (retire) begin
            instr_retired <= instr_retired + CNT_W'(1);
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct7      (funct7b5),
        .opcode5     (opcode[5]),
        .funct3      (funct3),
        .alu_control (alu_control)
    );

    // Write enables are gated by reset so nothing commits while rst_n is low.
    assign imm_src       = imm_src_for(opcode);
    assign pc_write      = rst_n & ((branch & zero) | pc_update);
    assign ir_write      = rst_n & ir_write_int;
    assign mem_write     = rst_n & mem_write_int;
    assign reg_write     = rst_n & reg_write_int;
    assign illegal_instr = rst_n & illegal_int;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction phase model
// pushes the expected output set for every cycle; a negedge monitor pops and
// compares against the DUT.
module tb_multicycle_controller;

    localparam int CW = 4;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BQ  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMREAD = 3,
                   P_MEMWB = 4, P_MEMWRITE = 5, P_EXR = 6, P_EXI = 7,
                   P_ALUWB = 8, P_BEQ = 9, P_JAL = 10;

    typedef struct packed {
        logic          pc_write;
        logic          adr_src;
        logic          mem_write;
        logic          ir_write;
        logic [1:0]    result_src;
        logic [1:0]    alu_src_a;
        logic [1:0]    alu_src_b;
        logic [1:0]    imm_src;
        logic          reg_write;
        logic [2:0]    alu_control;
        logic          illegal;
        logic [CW-1:0] retired;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [6:0]    opcode = 7'd0;
    logic [2:0]    funct3 = 3'd0;
    logic          funct7b5 = 1'b0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
    logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0]    alu_control;
    logic [CW-1:0] instr_retired;

    obs_t          exp_q[$];
    logic [CW-1:0] model_cnt = '0;
    logic [6:0]    cur_opc;
    logic [2:0]    cur_f3;
    logic          cur_f7;
    int            total = 0;
    int            bad = 0;
    int            cyc = 0;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7b5      (funct7b5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .adr_src       (adr_src),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .result_src    (result_src),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .imm_src       (imm_src),
        .reg_write     (reg_write),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .instr_retired (instr_retired)
    );

    always #5 clk = ~clk;

    function automatic logic is_legal(input logic [6:0] opc);
        return (opc == LW) || (opc == SW) || (opc == RT) || (opc == IT) ||
               (opc == BQ) || (opc == JL);
    endfunction

    function automatic logic [2:0] ref_alu(input logic [2:0] f3, input logic op5, input logic f7);
        logic [2:0] r;
        case (f3)
            3'b000:  r = (op5 && f7) ? 3'b001 : 3'b000;
            3'b010:  r = 3'b101;
            3'b110:  r = 3'b011;
            3'b111:  r = 3'b010;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    // Expected outputs for one cycle spent in a given instruction phase.
    function automatic obs_t model(input int ph, input logic rdy, input logic z,
                                   input logic [6:0] opc, input logic [2:0] f3,
                                   input logic f7, input logic ill);
        obs_t o;
        int   aop;
        o   = '0;
        aop = 0;
        case (ph)
            P_FETCH:    begin o.alu_src_b = 2'b10; o.result_src = 2'b10;
                              o.ir_write = rdy; o.pc_write = rdy; end
            P_DECODE:   begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b01; o.illegal = ill; end
            P_MEMADR:   begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; end
            P_MEMREAD:  o.adr_src = 1'b1;
            P_MEMWB:    begin o.result_src = 2'b01; o.reg_write = 1'b1; end
            P_MEMWRITE: begin o.adr_src = 1'b1; o.mem_write = 1'b1; end
            P_EXR:      begin o.alu_src_a = 2'b10; aop = 2; end
            P_EXI:      begin o.alu_src_a = 2'b10; o.alu_src_b = 2'b01; aop = 2; end
            P_ALUWB:    o.reg_write = 1'b1;
            P_BEQ:      begin o.alu_src_a = 2'b10; aop = 1; o.pc_write = z; end
            P_JAL:      begin o.alu_src_a = 2'b01; o.alu_src_b = 2'b10; o.pc_write = 1'b1; end
            default:    o = '0;
        endcase
        o.imm_src = (opc == SW) ? 2'b01 : (opc == BQ) ? 2'b10 : (opc == JL) ? 2'b11 : 2'b00;
        o.alu_control = (aop == 1) ? 3'b001 : (aop == 2) ? ref_alu(f3, opc[5], f7) : 3'b000;
        return o;
    endfunction

    task automatic do_cycle(input int ph, input logic rdy, input logic ill);
        obs_t e;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        opcode    = cur_opc;
        funct3    = cur_f3;
        funct7b5  = cur_f7;
        mem_ready = rdy;
        zero      = 1'($urandom_range(0, 1));
        e         = model(ph, rdy, zero, cur_opc, cur_f3, cur_f7, ill);
        e.retired = model_cnt;
        exp_q.push_back(e);
    endtask

    // A cycle held in reset: FETCH decode visible, every enable low, count 0.
    task automatic reset_cycle();
        obs_t e;
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        model_cnt = '0;
        mem_ready = 1'($urandom_range(0, 1));
        zero      = 1'($urandom_range(0, 1));
        e         = model(P_FETCH, 1'b0, zero, opcode, funct3, funct7b5, 1'b0);
        e.retired = '0;
        exp_q.push_back(e);
    endtask

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                             input int fw, input int mw);
        logic ill;
        cur_opc = opc;
        cur_f3  = f3;
        cur_f7  = f7;
        ill     = !is_legal(opc);
        for (int i = 0; i <= fw; i++) do_cycle(P_FETCH, i == fw, 1'b0);
        do_cycle(P_DECODE, rnd(), ill);
        if (ill) return;
        case (opc)
            LW: begin
                do_cycle(P_MEMADR, rnd(), 1'b0);
                for (int i = 0; i <= mw; i++) do_cycle(P_MEMREAD, i == mw, 1'b0);
                do_cycle(P_MEMWB, rnd(), 1'b0);
            end
            SW: begin
                do_cycle(P_MEMADR, rnd(), 1'b0);
                for (int i = 0; i <= mw; i++) do_cycle(P_MEMWRITE, i == mw, 1'b0);
            end
            RT: begin do_cycle(P_EXR, rnd(), 1'b0); do_cycle(P_ALUWB, rnd(), 1'b0); end
            IT: begin do_cycle(P_EXI, rnd(), 1'b0); do_cycle(P_ALUWB, rnd(), 1'b0); end
            BQ: do_cycle(P_BEQ, rnd(), 1'b0);
            default: begin do_cycle(P_JAL, rnd(), 1'b0); do_cycle(P_ALUWB, rnd(), 1'b0); end
        endcase
        model_cnt = model_cnt + 1'b1;
    endtask

    // Monitor: one expected record per cycle, compared mid-cycle.
    always @(negedge clk) begin
        obs_t e, g;
        cyc++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, imm_src, reg_write, alu_control, illegal_instr, instr_retired};
            total++;
            if (g !== e) begin
                bad++;
                $display("FAIL outputs cycle %0d: got=%h expected=%h (pcw,adr,mw,irw,res,a,b,imm,rw,alu,ill,cnt)",
                         cyc, g, e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [6:0] ropc;
        int         k;
        reset_cycle();
        reset_cycle();
        // Directed: ALU ops, memory with stalls, branches, jump, illegal.
        run_instr(RT, 3'b000, 1'b0, 0, 0);
        run_instr(RT, 3'b000, 1'b1, 0, 0);
        run_instr(IT, 3'b000, 1'b1, 0, 0);
        run_instr(RT, 3'b010, 1'b0, 0, 0);
        run_instr(RT, 3'b110, 1'b0, 0, 0);
        run_instr(RT, 3'b111, 1'b0, 0, 0);
        run_instr(LW, 3'b010, 1'b0, 0, 2);
        run_instr(SW, 3'b010, 1'b0, 0, 1);
        run_instr(BQ, 3'b000, 1'b0, 0, 0);
        run_instr(BQ, 3'b000, 1'b0, 1, 0);
        run_instr(JL, 3'b000, 1'b0, 0, 0);
        run_instr(7'b1111111, 3'b000, 1'b0, 0, 0);
        run_instr(IT, 3'b111, 1'b1, 2, 0);
        // Random mix; counter is 4 bits wide so it wraps several times.
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: ropc = LW;
                1: ropc = SW;
                2: ropc = RT;
                3: ropc = IT;
                4: ropc = BQ;
                5: ropc = JL;
                default: begin
                    ropc = 7'($urandom);
                    if (is_legal(ropc)) ropc = 7'b1111111;
                end
            endcase
            run_instr(ropc, 3'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        // Reset while a store is stalled in MEMWRITE.
        cur_opc = SW; cur_f3 = 3'b010; cur_f7 = 1'b0;
        do_cycle(P_FETCH, 1'b1, 1'b0);
        do_cycle(P_DECODE, 1'b1, 1'b0);
        do_cycle(P_MEMADR, 1'b1, 1'b0);
        do_cycle(P_MEMWRITE, 1'b0, 1'b0);
        do_cycle(P_MEMWRITE, 1'b0, 1'b0);
        reset_cycle();
        run_instr(RT, 3'b110, 1'b0, 0, 0);
        run_instr(BQ, 3'b000, 1'b0, 0, 0);
        @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d left expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control FSM for the multicycle RV32I subset core: lw, sw, R-type, I-type ALU, beq, jal.
- Sequences the shared ALU, register file, PC, IR and unified memory port across FETCH/DECODE/EXECUTE/WB states.
- Derives ALUControl through the ALU-control decoder.
- Adds a memory-ready handshake, an illegal-opcode flag and a retired-instruction counter.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  7  instr[6:0]
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
pc_write  out  1  PC enable
adr_src  out  1  0=PC, 1=Result
mem_write  out  1  memory write strobe
ir_write  out  1  IR/OldPC enable
result_src  out  2  00=ALUOut, 01=Data, 10=ALUResult
alu_src_a  out  2  00=PC, 01=OldPC, 10=RegA
alu_src_b  out  2  00=RegB, 01=ImmExt, 10=const 4
imm_src  out  2  00=I, 01=S, 10=B, 11=J
reg_write  out  1  register-file write enable
alu_control  out  3  add 000, sub 001, and 010, or 011, slt 101
illegal_instr  out  1  one-cycle pulse on unknown opcode
instr_retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst_n low sets state to FETCH and instr_retired to 0 asynchronously. While rst_n is low, pc_write, ir_write, reg_write, mem_write and illegal_instr are forced to 0; other outputs show the FETCH decode.
- Outputs are Moore, decoded from state. Exceptions:
  - pc_write = (branch & zero) | pc_update.
  - imm_src is combinational from opcode: lw/I-ALU=00, sw=01, beq=10, jal=11, other=00.
- ALU op field (internal): 00 forces add, 01 forces sub, 10 defers to funct3/funct7b5.
  - 010 = slt, 110 = or, 111 = and.
  - 000 gives sub only when {opcode[5], funct7b5} = 11, otherwise add (addi is always add).
  - Any other funct3 gives add.
- States, listing outputs asserted (unlisted enables = 0, selects = 00) and transition:
  - FETCH: adr_src 0, alu_src_a 00, alu_src_b 10, op 00, result_src 10. ir_write and pc_update assert only when mem_ready. Goes to DECODE when mem_ready; otherwise holds.
  - DECODE: alu_src_a 01, alu_src_b 01, op 00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> FETCH with illegal_instr high for this one cycle.
  - MEMADR: alu_src_a 10, alu_src_b 01, op 00. Goes to MEMREAD if opcode=0000011, else MEMWRITE.
  - MEMREAD: adr_src 1, result_src 00. Goes to MEMWB when mem_ready; otherwise holds.
  - MEMWB: result_src 01, reg_write. Goes to FETCH.
  - MEMWRITE: adr_src 1, result_src 00, mem_write held high until mem_ready. Goes to FETCH in the mem_ready cycle.
  - EXECUTER: alu_src_a 10, alu_src_b 00, op 10. Goes to ALUWB.
  - EXECUTEI: alu_src_a 10, alu_src_b 01, op 10. Goes to ALUWB.
  - ALUWB: result_src 00, reg_write. Goes to FETCH.
  - BEQ: alu_src_a 10, alu_src_b 00, op 01, result_src 00, branch. Goes to FETCH.
  - JAL: alu_src_a 01, alu_src_b 10, op 00, result_src 00, pc_update. Goes to ALUWB.
- Latency with mem_ready tied high:
  - lw = 5 cycles.
  - sw, R-type, I-type, jal = 4 cycles.
  - beq = 3 cycles.
  - Each mem_ready-low cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- instr_retired: increments by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ. It wraps modulo 2^CNT_W. An illegal opcode does not retire.
- Reset mid-instruction: abandon the instruction immediately, no write enables assert, restart in FETCH.
- Unreachable state encodings go to FETCH.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALU op, ALUControl, result_src, alu_src_a/b and imm_src encodings.
- Sub-module: the existing alu_decoder, instantiated unchanged.
  - Inputs: ALUOp = internal op, funct7 = funct7b5, opcode5 = opcode[5], funct3.
  - Output: ALUControl = alu_control.

Test Plan:
- Reset then add x3,x1,x2 (opcode 0110011, f3 000, f7b5 0), mem_ready=1 -> state path FETCH, DECODE, EXECUTER, ALUWB. alu_control = 000 in EXECUTER; reg_write=1 only in ALUWB; instr_retired = 1.
- sub (f7b5=1) and addi with instr[30]=1 (opcode 0010011) -> alu_control 001 and 000 respectively; slt -> 101; or -> 011; and -> 010.
- lw with mem_ready low 2 cycles in MEMREAD -> 7 cycles total, result_src 01 in MEMWB; sw with ready low 1 cycle -> mem_write high 2 consecutive cycles, then FETCH.
- beq with zero=1 -> pc_write=1 in BEQ with alu_control 001; zero=0 -> pc_write=0 in BEQ. jal -> pc_write in JAL, reg_write in ALUWB, imm_src 11.
- Opcode 1111111 -> illegal_instr single pulse in DECODE, back to FETCH, instr_retired unchanged.
- Assert rst_n low during MEMWRITE -> mem_write drops immediately, counter = 0, FETCH after release. CNT_W=4 with 16 retirements -> counter wraps to 0.
